decode_stage: RTL and testbench

Registered RV32I instruction-decode pipeline stage, optionally extended with RV32M decode, sitting between fetch and EX. It decodes one instruction per cycle, reads the GRF, applies write-back forwarding, detects load-use hazards, and holds its result in an output register with a valid/ready handshake. Flush support and a stall-cycle counter are included for branch recovery and performance monitoring.

---
 rtl/decode_stage_if.sv | 62 ++++++
 rtl/decode_stage.sv | 206 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch -> ID -> EX bundle for decode_stage: fetch handshake, GRF read/forward
// ports, hazard inputs and the registered decode payload.
interface decode_stage_if #(
  parameter bit EN_M = 1'b0
);
  localparam int ALU_W = 12 + 8 * int'(EN_M);

  logic             i_Valid_1;
  logic             o_Ready_1;
  logic [31:0]      i_PC_32;
  logic [31:0]      i_Inst_32;
  logic [4:0]       o_GRFReadAddr1_5;
  logic [4:0]       o_GRFReadAddr2_5;
  logic [31:0]      i_GRFReadData1_32;
  logic [31:0]      i_GRFReadData2_32;
  logic             i_FwdWen_1;
  logic [4:0]       i_FwdAddr_5;
  logic [31:0]      i_FwdData_32;
  logic             i_EXLoad_1;
  logic [4:0]       i_EXRd_5;
  logic             i_Flush_1;
  logic             o_Valid_1;
  logic             i_Ready_1;
  logic [31:0]      o_PC_32;
  logic [31:0]      o_Imm_32;
  logic [31:0]      o_ALUOperand1_32;
  logic [31:0]      o_ALUOperand2_32;
  logic [31:0]      o_RS2Data_32;
  logic [ALU_W-1:0] o_ALUControl;
  logic [4:0]       o_GRFWriteAddr_5;
  logic             o_GRFWen_1;
  logic             o_Load_1;
  logic             o_Store_1;
  logic             o_LoadSign_1;
  logic [1:0]       o_LoadStoreWidth_2;
  logic [7:0]       o_JumpBranchType_8;
  logic             o_UnsignedCMP_1;
  logic             o_Illegal_1;
  logic [31:0]      o_StallCnt_32;

  modport master (
    output i_Valid_1, i_PC_32, i_Inst_32, i_GRFReadData1_32, i_GRFReadData2_32,
           i_FwdWen_1, i_FwdAddr_5, i_FwdData_32, i_EXLoad_1, i_EXRd_5,
           i_Flush_1, i_Ready_1,
    input  o_Ready_1, o_GRFReadAddr1_5, o_GRFReadAddr2_5, o_Valid_1, o_PC_32,
           o_Imm_32, o_ALUOperand1_32, o_ALUOperand2_32, o_RS2Data_32,
           o_ALUControl, o_GRFWriteAddr_5, o_GRFWen_1, o_Load_1, o_Store_1,
           o_LoadSign_1, o_LoadStoreWidth_2, o_JumpBranchType_8,
           o_UnsignedCMP_1, o_Illegal_1, o_StallCnt_32
  );

  modport slave (
    input  i_Valid_1, i_PC_32, i_Inst_32, i_GRFReadData1_32, i_GRFReadData2_32,
           i_FwdWen_1, i_FwdAddr_5, i_FwdData_32, i_EXLoad_1, i_EXRd_5,
           i_Flush_1, i_Ready_1,
    output o_Ready_1, o_GRFReadAddr1_5, o_GRFReadAddr2_5, o_Valid_1, o_PC_32,
           o_Imm_32, o_ALUOperand1_32, o_ALUOperand2_32, o_RS2Data_32,
           o_ALUControl, o_GRFWriteAddr_5, o_GRFWen_1, o_Load_1, o_Store_1,
           o_LoadSign_1, o_LoadStoreWidth_2, o_JumpBranchType_8,
           o_UnsignedCMP_1, o_Illegal_1, o_StallCnt_32
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: decode, GRF read with write-back forwarding,
// load-use hazard detection and a valid/ready output register.
module decode_stage #(
  parameter bit EN_M = 1'b0
) (
  input logic          i_Clk_1,
  input logic          i_RstN_1,
  decode_stage_if.slave bus
);
  localparam int ALU_W = 12 + 8 * int'(EN_M);

  localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL    = 7'b1101111, OPC_JALR  = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD  = 7'b0000011,
                         OPC_STORE  = 7'b0100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP     = 7'b0110011, OPC_FENCE = 7'b0001111,
                         OPC_SYSTEM = 7'b1110011;

  localparam int A_ADD = 11, A_PC4 = 10, A_SUB = 9, A_SLT = 8, A_SLTU = 7, A_AND = 6,
                 A_OR = 5, A_XOR = 4, A_SLL = 3, A_SRL = 2, A_SRA = 1, A_LUI = 0;

  function automatic logic [11:0] f3_alu(input logic [2:0] f3, input logic alt);
    logic [11:0] v;
    v = '0;
    case (f3)
      3'b000:  v[alt ? A_SUB : A_ADD] = 1'b1;
      3'b001:  v[A_SLL]  = 1'b1;
      3'b010:  v[A_SLT]  = 1'b1;
      3'b011:  v[A_SLTU] = 1'b1;
      3'b100:  v[A_XOR]  = 1'b1;
      3'b101:  v[alt ? A_SRA : A_SRL] = 1'b1;
      3'b110:  v[A_OR]   = 1'b1;
      default: v[A_AND]  = 1'b1;
    endcase
    return v;
  endfunction

  logic [31:0] w_inst;
  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_legal, w_wen_op, w_load, w_store, w_rs1_used, w_rs2_used;
  logic        w_op1_pc, w_op2_rs2;
  logic [31:0] w_imm, w_rs1_fwd, w_rs2_fwd;
  logic [ALU_W-1:0] w_alu;
  logic [7:0]  w_jbt;
  logic        w_hazard, w_advance, w_accept;

  assign w_inst   = bus.i_Inst_32;
  assign w_opcode = w_inst[6:0];
  assign w_rd     = w_inst[11:7];
  assign w_f3     = w_inst[14:12];
  assign w_rs1    = w_inst[19:15];
  assign w_rs2    = w_inst[24:20];
  assign w_f7     = w_inst[31:25];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_legal = 1'b0; w_wen_op = 1'b0; w_load = 1'b0; w_store = 1'b0;
    w_rs1_used = 1'b1; w_rs2_used = 1'b0; w_op1_pc = 1'b0; w_op2_rs2 = 1'b0;
    w_imm = '0; w_alu = '0; w_jbt = '0;
    case (w_opcode)
      OPC_LUI: begin
        w_legal = 1'b1; w_wen_op = 1'b1; w_rs1_used = 1'b0;
        w_imm = {w_inst[31:12], 12'b0}; w_alu[A_LUI] = 1'b1;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1; w_wen_op = 1'b1; w_rs1_used = 1'b0; w_op1_pc = 1'b1;
        w_imm = {w_inst[31:12], 12'b0}; w_alu[A_ADD] = 1'b1;
      end
      OPC_JAL: begin
        w_legal = 1'b1; w_wen_op = 1'b1; w_rs1_used = 1'b0; w_op1_pc = 1'b1;
        w_imm = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
        w_alu[A_PC4] = 1'b1; w_jbt[7] = 1'b1;
      end
      OPC_JALR: begin
        w_legal = (w_f3 == 3'b000); w_wen_op = 1'b1;
        w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
        w_alu[A_PC4] = 1'b1; w_jbt[6] = 1'b1;
      end
      OPC_BRANCH: begin
        w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011); w_rs2_used = 1'b1;
        w_imm = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
        case (w_f3)
          3'b000:  w_jbt[5] = 1'b1;
          3'b001:  w_jbt[4] = 1'b1;
          3'b100:  w_jbt[3] = 1'b1;
          3'b110:  w_jbt[2] = 1'b1;
          3'b101:  w_jbt[1] = 1'b1;
          3'b111:  w_jbt[0] = 1'b1;
          default: w_jbt = '0;
        endcase
      end
      OPC_LOAD: begin
        w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
        w_wen_op = 1'b1; w_load = 1'b1; w_alu[A_ADD] = 1'b1;
        w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OPC_STORE: begin
        w_legal = (w_f3 < 3'b011); w_store = 1'b1; w_rs2_used = 1'b1;
        w_alu[A_ADD] = 1'b1;
        w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      end
      OPC_OPIMM: begin
        w_wen_op = 1'b1; w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
        case (w_f3)
          3'b001:  w_legal = (w_f7 == 7'b0000000);
          3'b101:  w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          default: w_legal = 1'b1;
        endcase
        // Only shifts use bit 30 as a variant select; ADDI's bit 30 is immediate.
        w_alu[11:0] = f3_alu(w_f3, (w_f3 == 3'b101) && w_inst[30]);
      end
      OPC_OP: begin
        w_wen_op = 1'b1; w_rs2_used = 1'b1; w_op2_rs2 = 1'b1;
        if ((w_f7 == 7'b0000000) ||
            ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))) begin
          w_legal = 1'b1;
          w_alu[11:0] = f3_alu(w_f3, w_inst[30]);
        end else if (EN_M && (w_f7 == 7'b0000001)) begin
          w_legal = 1'b1;
          for (int k = 12; k < ALU_W; k++) w_alu[k] = (k == 19 - int'(w_f3));
        end
      end
      OPC_FENCE:  w_legal = (w_f3 == 3'b000);
      OPC_SYSTEM: w_legal = (w_inst == 32'h0000_0073) || (w_inst == 32'h0010_0073);
      default:    w_legal = 1'b0;
    endcase
  end

  assign w_rs1_fwd = (bus.i_FwdWen_1 && (bus.i_FwdAddr_5 != 5'd0) && (bus.i_FwdAddr_5 == w_rs1))
                     ? bus.i_FwdData_32 : bus.i_GRFReadData1_32;
  assign w_rs2_fwd = (bus.i_FwdWen_1 && (bus.i_FwdAddr_5 != 5'd0) && (bus.i_FwdAddr_5 == w_rs2))
                     ? bus.i_FwdData_32 : bus.i_GRFReadData2_32;

  assign w_hazard  = bus.i_Valid_1 && bus.i_EXLoad_1 && (bus.i_EXRd_5 != 5'd0) &&
                     ((w_rs1_used && (w_rs1 == bus.i_EXRd_5)) ||
                      (w_rs2_used && (w_rs2 == bus.i_EXRd_5)));
  assign w_advance = !bus.o_Valid_1 || bus.i_Ready_1;
  assign w_accept  = bus.i_Valid_1 && !w_hazard;

  assign bus.o_Ready_1        = bus.i_Flush_1 || (w_advance && !w_hazard);
  assign bus.o_GRFReadAddr1_5 = w_rs1;
  assign bus.o_GRFReadAddr2_5 = w_rs2;

  logic             r_valid, r_wen, r_load, r_store, r_load_sign, r_ucmp, r_illegal;
  logic [31:0]      r_pc, r_imm, r_op1, r_op2, r_rs2_data, r_stall_cnt;
  logic [ALU_W-1:0] r_alu;
  logic [4:0]       r_waddr;
  logic [1:0]       r_width;
  logic [7:0]       r_jbt;

  // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_Clk_1 or negedge i_RstN_1) begin
    if (!i_RstN_1) begin
      r_valid <= 1'b0; r_wen <= 1'b0; r_load <= 1'b0; r_store <= 1'b0;
      r_load_sign <= 1'b0; r_ucmp <= 1'b0; r_illegal <= 1'b0;
      r_pc <= '0; r_imm <= '0; r_op1 <= '0; r_op2 <= '0; r_rs2_data <= '0;
      r_alu <= '0; r_waddr <= '0; r_width <= '0; r_jbt <= '0; r_stall_cnt <= '0;
    end else begin
      if (bus.i_Flush_1) begin
        r_valid <= 1'b0;
      end else if (w_advance) begin
        r_valid <= w_accept;
        if (w_accept) begin
          r_pc        <= bus.i_PC_32;
          r_imm       <= w_imm;
          r_op1       <= w_op1_pc ? bus.i_PC_32 : w_rs1_fwd;
          r_op2       <= w_op2_rs2 ? w_rs2_fwd : w_imm;
          r_rs2_data  <= w_rs2_fwd;
          r_waddr     <= w_rd;
          r_illegal   <= !w_legal;
          r_wen       <= w_legal && w_wen_op && (w_rd != 5'd0);
          r_load      <= w_legal && w_load;
          r_store     <= w_legal && w_store;
          r_load_sign <= w_legal && w_load && !w_f3[2];
          r_width     <= (w_legal && (w_load || w_store))
                         ? ((w_f3[1:0] == 2'b10) ? 2'b11 : w_f3[1:0]) : 2'b00;
          r_alu       <= w_legal ? w_alu : '0;
          r_jbt       <= w_legal ? w_jbt : '0;
          r_ucmp      <= w_legal && (w_jbt[2] || w_jbt[0]);
        end
      end
      if (w_hazard && !bus.i_Flush_1 && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.o_Valid_1          = r_valid;
  assign bus.o_PC_32            = r_pc;
  assign bus.o_Imm_32           = r_imm;
  assign bus.o_ALUOperand1_32   = r_op1;
  assign bus.o_ALUOperand2_32   = r_op2;
  assign bus.o_RS2Data_32       = r_rs2_data;
  assign bus.o_ALUControl       = r_alu;
  assign bus.o_GRFWriteAddr_5   = r_waddr;
  assign bus.o_GRFWen_1         = r_wen;
  assign bus.o_Load_1           = r_load;
  assign bus.o_Store_1          = r_store;
  assign bus.o_LoadSign_1       = r_load_sign;
  assign bus.o_LoadStoreWidth_2 = r_width;
  assign bus.o_JumpBranchType_8 = r_jbt;
  assign bus.o_UnsignedCMP_1    = r_ucmp;
  assign bus.o_Illegal_1        = r_illegal;
  assign bus.o_StallCnt_32      = r_stall_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one RV32M-enabled and one RV32I-only instance
// share the same stimulus; expectations are hand-computed constants.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid = 1'b0, fwen = 1'b0, exload = 1'b0, flush = 1'b0, dready = 1'b1;
  logic [31:0] pc = '0, inst = '0, grf1 = '0, grf2 = '0, fdata = '0;
  logic [4:0]  faddr = '0, exrd = '0;

  int n_tot = 0;
  int n_pass = 0;

  decode_stage_if #(.EN_M(1'b1)) bus_m ();
  decode_stage_if #(.EN_M(1'b0)) bus_i ();

  assign bus_m.i_Valid_1 = valid;          assign bus_i.i_Valid_1 = valid;
  assign bus_m.i_PC_32 = pc;               assign bus_i.i_PC_32 = pc;
  assign bus_m.i_Inst_32 = inst;           assign bus_i.i_Inst_32 = inst;
  assign bus_m.i_GRFReadData1_32 = grf1;   assign bus_i.i_GRFReadData1_32 = grf1;
  assign bus_m.i_GRFReadData2_32 = grf2;   assign bus_i.i_GRFReadData2_32 = grf2;
  assign bus_m.i_FwdWen_1 = fwen;          assign bus_i.i_FwdWen_1 = fwen;
  assign bus_m.i_FwdAddr_5 = faddr;        assign bus_i.i_FwdAddr_5 = faddr;
  assign bus_m.i_FwdData_32 = fdata;       assign bus_i.i_FwdData_32 = fdata;
  assign bus_m.i_EXLoad_1 = exload;        assign bus_i.i_EXLoad_1 = exload;
  assign bus_m.i_EXRd_5 = exrd;            assign bus_i.i_EXRd_5 = exrd;
  assign bus_m.i_Flush_1 = flush;          assign bus_i.i_Flush_1 = flush;
  assign bus_m.i_Ready_1 = dready;         assign bus_i.i_Ready_1 = dready;

  decode_stage #(.EN_M(1'b1)) u_dut_m (.i_Clk_1(clk), .i_RstN_1(rst_n), .bus(bus_m.slave));
  decode_stage #(.EN_M(1'b0)) u_dut_i (.i_Clk_1(clk), .i_RstN_1(rst_n), .bus(bus_i.slave));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    n_tot++; if (bus_m.o_Valid_1 !== 1'b0) $display("FAIL rst_valid got=%h exp=0", bus_m.o_Valid_1); else n_pass++;
    n_tot++; if (bus_m.o_PC_32 !== 32'h0) $display("FAIL rst_pc got=%h exp=0", bus_m.o_PC_32); else n_pass++;
    n_tot++; if (bus_m.o_ALUControl !== 20'h0) $display("FAIL rst_alu got=%h exp=0", bus_m.o_ALUControl); else n_pass++;
    n_tot++; if (bus_m.o_StallCnt_32 !== 32'h0) $display("FAIL rst_stall got=%h exp=0", bus_m.o_StallCnt_32); else n_pass++;
    n_tot++; if (bus_m.o_Ready_1 !== 1'b1) $display("FAIL rst_ready got=%h exp=1", bus_m.o_Ready_1); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    valid = 1'b1; pc = 32'h100; inst = 32'h0050_0093; dready = 1'b1;
    settle();
    n_tot++; if (bus_m.o_Ready_1 !== 1'b1) $display("FAIL addi_ready got=%h exp=1", bus_m.o_Ready_1); else n_pass++;
    tick();
    n_tot++; if (bus_m.o_Valid_1 !== 1'b1) $display("FAIL addi_valid got=%h exp=1", bus_m.o_Valid_1); else n_pass++;
    n_tot++; if (bus_m.o_ALUOperand2_32 !== 32'd5) $display("FAIL addi_op2 got=%h exp=5", bus_m.o_ALUOperand2_32); else n_pass++;
    n_tot++; if (bus_m.o_ALUControl !== 20'h00800) $display("FAIL addi_alu got=%h exp=00800", bus_m.o_ALUControl); else n_pass++;
    n_tot++; if (bus_i.o_ALUControl !== 12'h800) $display("FAIL addi_alu_i got=%h exp=800", bus_i.o_ALUControl); else n_pass++;
    n_tot++; if (bus_m.o_GRFWen_1 !== 1'b1) $display("FAIL addi_wen got=%h exp=1", bus_m.o_GRFWen_1); else n_pass++;
    n_tot++; if (bus_m.o_GRFWriteAddr_5 !== 5'd1) $display("FAIL addi_waddr got=%h exp=1", bus_m.o_GRFWriteAddr_5); else n_pass++;
    n_tot++; if (bus_m.o_PC_32 !== 32'h100) $display("FAIL addi_pc got=%h exp=100", bus_m.o_PC_32); else n_pass++;
    n_tot++; if (bus_m.o_Illegal_1 !== 1'b0) $display("FAIL addi_illegal got=%h exp=0", bus_m.o_Illegal_1); else n_pass++;
  endtask

  task automatic test_forward();
    inst = 32'h0012_8333; pc = 32'h104; grf1 = 32'h11; grf2 = 32'h22;
    fwen = 1'b1; faddr = 5'd5; fdata = 32'hDEAD;
    settle();
    n_tot++; if (bus_m.o_GRFReadAddr1_5 !== 5'd5) $display("FAIL fwd_ra1 got=%h exp=5", bus_m.o_GRFReadAddr1_5); else n_pass++;
    n_tot++; if (bus_m.o_GRFReadAddr2_5 !== 5'd1) $display("FAIL fwd_ra2 got=%h exp=1", bus_m.o_GRFReadAddr2_5); else n_pass++;
    tick();
    n_tot++; if (bus_m.o_ALUOperand1_32 !== 32'hDEAD) $display("FAIL fwd_op1 got=%h exp=DEAD", bus_m.o_ALUOperand1_32); else n_pass++;
    n_tot++; if (bus_m.o_ALUOperand2_32 !== 32'h22) $display("FAIL fwd_op2_grf got=%h exp=22", bus_m.o_ALUOperand2_32); else n_pass++;
    faddr = 5'd0;
    tick();
    n_tot++; if (bus_m.o_ALUOperand1_32 !== 32'h11) $display("FAIL fwd_x0 got=%h exp=11", bus_m.o_ALUOperand1_32); else n_pass++;
    faddr = 5'd1; fdata = 32'hBEEF;
    tick();
    n_tot++; if (bus_m.o_ALUOperand2_32 !== 32'hBEEF) $display("FAIL fwd_op2 got=%h exp=BEEF", bus_m.o_ALUOperand2_32); else n_pass++;
    n_tot++; if (bus_m.o_RS2Data_32 !== 32'hBEEF) $display("FAIL fwd_rs2data got=%h exp=BEEF", bus_m.o_RS2Data_32); else n_pass++;
    n_tot++; if (bus_m.o_ALUOperand1_32 !== 32'h11) $display("FAIL fwd_op1_grf got=%h exp=11", bus_m.o_ALUOperand1_32); else n_pass++;
    fwen = 1'b0; faddr = 5'd0;
  endtask

  task automatic test_load_use();
    inst = 32'h0012_8333; pc = 32'h104; exload = 1'b1; exrd = 5'd5;
    settle();
    n_tot++; if (bus_m.o_Ready_1 !== 1'b0) $display("FAIL lu_ready got=%h exp=0", bus_m.o_Ready_1); else n_pass++;
    tick();
    n_tot++; if (bus_m.o_Valid_1 !== 1'b0) $display("FAIL lu_bubble got=%h exp=0", bus_m.o_Valid_1); else n_pass++;
    n_tot++; if (bus_m.o_StallCnt_32 !== 32'd1) $display("FAIL lu_stall got=%h exp=1", bus_m.o_StallCnt_32); else n_pass++;
    exload = 1'b0;
    settle();
    n_tot++; if (bus_m.o_Ready_1 !== 1'b1) $display("FAIL lu_ready2 got=%h exp=1", bus_m.o_Ready_1); else n_pass++;
    tick();
    n_tot++; if (bus_m.o_Valid_1 !== 1'b1) $display("FAIL lu_issue got=%h exp=1", bus_m.o_Valid_1); else n_pass++;
    n_tot++; if (bus_m.o_GRFWriteAddr_5 !== 5'd6) $display("FAIL lu_waddr got=%h exp=6", bus_m.o_GRFWriteAddr_5); else n_pass++;
    // ADDI's rs2 field equals the load rd but rs2 is unused: no hazard.
    inst = 32'h0050_0093; pc = 32'h108; exload = 1'b1; exrd = 5'd5;
    settle();
    n_tot++; if (bus_m.o_Ready_1 !== 1'b1) $display("FAIL lu_rs2unused got=%h exp=1", bus_m.o_Ready_1); else n_pass++;
    tick();
    n_tot++; if (bus_m.o_PC_32 !== 32'h108) $display("FAIL lu_nohaz_pc got=%h exp=108", bus_m.o_PC_32); else n_pass++;
    n_tot++; if (bus_m.o_StallCnt_32 !== 32'd1) $display("FAIL lu_nohaz_stall got=%h exp=1", bus_m.o_StallCnt_32); else n_pass++;
    exload = 1'b0; exrd = 5'd0;
  endtask

  task automatic test_backpressure();
    dready = 1'b0; inst = 32'h0050_0093; pc = 32'h200;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_tot++; if (bus_m.o_Ready_1 !== 1'b0) $display("FAIL bp_ready c%0d got=%h exp=0", c, bus_m.o_Ready_1); else n_pass++;
      tick();
      n_tot++; if (bus_m.o_Valid_1 !== 1'b1) $display("FAIL bp_valid c%0d got=%h exp=1", c, bus_m.o_Valid_1); else n_pass++;
      n_tot++; if (bus_m.o_PC_32 !== 32'h108) $display("FAIL bp_pc c%0d got=%h exp=108", c, bus_m.o_PC_32); else n_pass++;
    end
    inst = 32'h0012_8333; exload = 1'b1; exrd = 5'd5;
    tick(); tick();
    n_tot++; if (bus_m.o_StallCnt_32 !== 32'd3) $display("FAIL bp_haz_stall got=%h exp=3", bus_m.o_StallCnt_32); else n_pass++;
    exload = 1'b0;
    tick();
    n_tot++; if (bus_m.o_StallCnt_32 !== 32'd3) $display("FAIL bp_nohaz_stall got=%h exp=3", bus_m.o_StallCnt_32); else n_pass++;
    n_tot++; if (bus_m.o_PC_32 !== 32'h108) $display("FAIL bp_hold_pc got=%h exp=108", bus_m.o_PC_32); else n_pass++;
    inst = 32'h0050_0093; dready = 1'b1;
    settle();
    n_tot++; if (bus_m.o_Ready_1 !== 1'b1) $display("FAIL bp_release_ready got=%h exp=1", bus_m.o_Ready_1); else n_pass++;
    tick();
    n_tot++; if (bus_m.o_PC_32 !== 32'h200) $display("FAIL bp_release_pc got=%h exp=200", bus_m.o_PC_32); else n_pass++;
  endtask

  task automatic test_flush();
    dready = 1'b0; inst = 32'h0012_8333; pc = 32'h204; exload = 1'b1; exrd = 5'd5; flush = 1'b1;
    settle();
    n_tot++; if (bus_m.o_Ready_1 !== 1'b1) $display("FAIL fl_ready got=%h exp=1", bus_m.o_Ready_1); else n_pass++;
    tick();
    n_tot++; if (bus_m.o_Valid_1 !== 1'b0) $display("FAIL fl_valid got=%h exp=0", bus_m.o_Valid_1); else n_pass++;
    n_tot++; if (bus_m.o_StallCnt_32 !== 32'd3) $display("FAIL fl_stall got=%h exp=3", bus_m.o_StallCnt_32); else n_pass++;
    flush = 1'b0; exload = 1'b0; exrd = 5'd0; dready = 1'b1;
  endtask

  task automatic test_formats();
    grf1 = 32'h1000; grf2 = 32'h22; pc = 32'h300;
    inst = 32'h0020_A423;  // SW x2,8(x1)
    tick();
    n_tot++; if (bus_m.o_Store_1 !== 1'b1) $display("FAIL sw_store got=%h exp=1", bus_m.o_Store_1); else n_pass++;
    n_tot++; if (bus_m.o_LoadStoreWidth_2 !== 2'b11) $display("FAIL sw_width got=%h exp=3", bus_m.o_LoadStoreWidth_2); else n_pass++;
    n_tot++; if (bus_m.o_Imm_32 !== 32'd8) $display("FAIL sw_imm got=%h exp=8", bus_m.o_Imm_32); else n_pass++;
    n_tot++; if (bus_m.o_GRFWen_1 !== 1'b0) $display("FAIL sw_wen got=%h exp=0", bus_m.o_GRFWen_1); else n_pass++;
    n_tot++; if (bus_m.o_RS2Data_32 !== 32'h22) $display("FAIL sw_rs2 got=%h exp=22", bus_m.o_RS2Data_32); else n_pass++;
    inst = 32'h0020_8463;  // BEQ x1,x2,+8
    tick();
    n_tot++; if (bus_m.o_JumpBranchType_8 !== 8'h20) $display("FAIL beq_jbt got=%h exp=20", bus_m.o_JumpBranchType_8); else n_pass++;
    n_tot++; if (bus_m.o_Imm_32 !== 32'd8) $display("FAIL beq_imm got=%h exp=8", bus_m.o_Imm_32); else n_pass++;
    n_tot++; if (bus_m.o_UnsignedCMP_1 !== 1'b0) $display("FAIL beq_ucmp got=%h exp=0", bus_m.o_UnsignedCMP_1); else n_pass++;
    inst = 32'hFFF0_8183;  // LB x3,-1(x1)
    tick();
    n_tot++; if (bus_m.o_Load_1 !== 1'b1) $display("FAIL lb_load got=%h exp=1", bus_m.o_Load_1); else n_pass++;
    n_tot++; if (bus_m.o_LoadSign_1 !== 1'b1) $display("FAIL lb_sign got=%h exp=1", bus_m.o_LoadSign_1); else n_pass++;
    n_tot++; if (bus_m.o_Imm_32 !== 32'hFFFF_FFFF) $display("FAIL lb_imm got=%h exp=FFFFFFFF", bus_m.o_Imm_32); else n_pass++;
    n_tot++; if (bus_m.o_LoadStoreWidth_2 !== 2'b00) $display("FAIL lb_width got=%h exp=0", bus_m.o_LoadStoreWidth_2); else n_pass++;
    inst = 32'h0100_00EF;  // JAL x1,+16
    tick();
    n_tot++; if (bus_m.o_ALUOperand1_32 !== 32'h300) $display("FAIL jal_op1 got=%h exp=300", bus_m.o_ALUOperand1_32); else n_pass++;
    n_tot++; if (bus_m.o_Imm_32 !== 32'd16) $display("FAIL jal_imm got=%h exp=10", bus_m.o_Imm_32); else n_pass++;
    n_tot++; if (bus_m.o_JumpBranchType_8 !== 8'h80) $display("FAIL jal_jbt got=%h exp=80", bus_m.o_JumpBranchType_8); else n_pass++;
    n_tot++; if (bus_m.o_ALUControl !== 20'h00400) $display("FAIL jal_alu got=%h exp=00400", bus_m.o_ALUControl); else n_pass++;
    inst = 32'h1234_52B7;  // LUI x5,0x12345
    tick();
    n_tot++; if (bus_m.o_ALUOperand2_32 !== 32'h1234_5000) $display("FAIL lui_op2 got=%h exp=12345000", bus_m.o_ALUOperand2_32); else n_pass++;
    n_tot++; if (bus_m.o_ALUControl !== 20'h00001) $display("FAIL lui_alu got=%h exp=00001", bus_m.o_ALUControl); else n_pass++;
    n_tot++; if (bus_m.o_GRFWriteAddr_5 !== 5'd5) $display("FAIL lui_waddr got=%h exp=5", bus_m.o_GRFWriteAddr_5); else n_pass++;
  endtask

  task automatic test_mul_illegal();
    inst = 32'h0220_81B3;  // MUL x3,x1,x2
    tick();
    n_tot++; if (bus_m.o_ALUControl !== 20'h80000) $display("FAIL mul_alu got=%h exp=80000", bus_m.o_ALUControl); else n_pass++;
    n_tot++; if (bus_m.o_GRFWen_1 !== 1'b1) $display("FAIL mul_wen got=%h exp=1", bus_m.o_GRFWen_1); else n_pass++;
    n_tot++; if (bus_m.o_Illegal_1 !== 1'b0) $display("FAIL mul_illegal got=%h exp=0", bus_m.o_Illegal_1); else n_pass++;
    n_tot++; if (bus_i.o_Illegal_1 !== 1'b1) $display("FAIL mul_i_illegal got=%h exp=1", bus_i.o_Illegal_1); else n_pass++;
    n_tot++; if (bus_i.o_GRFWen_1 !== 1'b0) $display("FAIL mul_i_wen got=%h exp=0", bus_i.o_GRFWen_1); else n_pass++;
    n_tot++; if (bus_i.o_ALUControl !== 12'h000) $display("FAIL mul_i_alu got=%h exp=0", bus_i.o_ALUControl); else n_pass++;
    n_tot++; if (bus_i.o_Valid_1 !== 1'b1) $display("FAIL mul_i_valid got=%h exp=1", bus_i.o_Valid_1); else n_pass++;
    inst = 32'hFFFF_FFFF;
    tick();
    n_tot++; if (bus_m.o_Illegal_1 !== 1'b1) $display("FAIL ill_flag got=%h exp=1", bus_m.o_Illegal_1); else n_pass++;
    n_tot++; if (bus_m.o_JumpBranchType_8 !== 8'h00) $display("FAIL ill_jbt got=%h exp=0", bus_m.o_JumpBranchType_8); else n_pass++;
    n_tot++; if (bus_m.o_Load_1 !== 1'b0) $display("FAIL ill_load got=%h exp=0", bus_m.o_Load_1); else n_pass++;
  endtask

  task automatic test_async_reset();
    inst = 32'h0050_0093; pc = 32'h400;
    tick();
    rst_n = 1'b0;
    settle();
    n_tot++; if (bus_m.o_Valid_1 !== 1'b0) $display("FAIL arst_valid got=%h exp=0", bus_m.o_Valid_1); else n_pass++;
    n_tot++; if (bus_m.o_PC_32 !== 32'h0) $display("FAIL arst_pc got=%h exp=0", bus_m.o_PC_32); else n_pass++;
    n_tot++; if (bus_m.o_StallCnt_32 !== 32'h0) $display("FAIL arst_stall got=%h exp=0", bus_m.o_StallCnt_32); else n_pass++;
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    valid = 1'b1;
    test_formats();
    test_mul_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
